// File: rtl/jseq_pkg.sv
// Shared constants and FSM state type for the serial pattern detector.
package jseq_pkg;

  localparam int         JSEQ_N       = 4;
  localparam logic [3:0] JSEQ_PATTERN = 4'b1011;
  localparam int         JSEQ_CW      = 4;

  typedef enum logic {
    FILL,
    ARMED
  } jseq_state_e;

endpackage

// File: rtl/jshiftreg.sv
// N-bit serial-in, parallel-out history register; newest bit enters at bit 0.
// Also exposes the value it will load on the next enabled edge.
module jshiftreg #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         din,
  output logic [N-1:0] hist,
  output logic [N-1:0] hist_next
);

  logic [N-1:0] hist_reg;

  assign hist_next[0] = din;

  generate
    for (genvar gi = 1; gi < N; gi++) begin : g_shift
      assign hist_next[gi] = hist_reg[gi-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_reg <= '0;
    end else if (en) begin
      hist_reg <= hist_next;
    end
  end

  assign hist = hist_reg;

endmodule

// File: rtl/jseq_detector.sv
// Serial pattern detector with saturating match counter.
// Define JSEQ_OVERLAP_EN for overlapping detection; default is non-overlapping.
module jseq_detector
  import jseq_pkg::*;
#(
  parameter int           N       = JSEQ_N,
  parameter logic [N-1:0] PATTERN = N'(JSEQ_PATTERN),
  parameter int           CW      = JSEQ_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          din,
  output logic          match,
  output logic [CW-1:0] count,
  output logic [N-1:0]  hist
);

  localparam int            FW       = $clog2(N + 1);
  localparam logic [FW-1:0] FILL_ARM = FW'(N - 1);
  localparam logic [FW-1:0] FILL_MAX = FW'(N);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  jseq_state_e   state_reg, state_next;
  logic [FW-1:0] fill_reg, fill_next;
  logic          match_reg, match_next;
  logic [CW-1:0] count_reg, count_next;
  logic [N-1:0]  shift_next;
  logic          hit;

  jshiftreg #(.N(N)) u_shift (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .din       (din),
    .hist      (hist),
    .hist_next (shift_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= FILL;
      fill_reg  <= '0;
      match_reg <= 1'b0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      fill_reg  <= fill_next;
      match_reg <= match_next;
      count_reg <= count_next;
    end
  end

  // ARMED means N-1 real bits are held, so the incoming bit completes a full window.
  always_comb begin
    state_next = state_reg;
    fill_next  = fill_reg;
    match_next = 1'b0;
    count_next = count_reg;
    hit        = 1'b0;
    if (en) begin
      hit = (state_reg == ARMED) && (shift_next == PATTERN);
      if (fill_reg != FILL_MAX) begin
        fill_next = fill_reg + 1'b1;
      end
      if (hit) begin
        match_next = 1'b1;
        if (count_reg != CNT_MAX) begin
          count_next = count_reg + 1'b1;
        end
`ifndef JSEQ_OVERLAP_EN
        fill_next = '0;
`endif
      end
      state_next = (fill_next >= FILL_ARM) ? ARMED : FILL;
    end
  end

  assign match = match_reg;
  assign count = count_reg;

endmodule

// File: tb/tb_jseq_detector.sv
// Self-checking bench for jseq_detector: directed scenarios plus randomized
// stream checked against a bit-history reference model.
module tb_jseq_detector;

  localparam int         N   = 4;
  localparam logic [3:0] PAT = 4'b1011;
  localparam int         CW  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en  = 1'b0;
  logic          din = 1'b0;
  logic          match;
  logic [CW-1:0] count;
  logic [N-1:0]  hist;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: every bit consumed since reset, plus count of fresh bits.
  bit   bits[$];
  int   fresh   = 0;
  int   hits    = 0;
  logic m_match = 1'b0;

  jseq_detector dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .din   (din),
    .match (match),
    .count (count),
    .hist  (hist)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] exp_hist();
    logic [N-1:0] h;
    int idx;
    h = '0;
    for (int i = 0; i < N; i++) begin
      idx = bits.size() - 1 - i;
      if (idx >= 0) h[i] = bits[idx];
    end
    return h;
  endfunction

  function automatic logic [CW-1:0] exp_count();
    return (hits > 15) ? CW'(15) : CW'(hits);
  endfunction

  task automatic tick(input logic r, input logic e, input logic d);
    logic [N-1:0] pv;
    bit hit;
    int sz;
    pv  = PAT;
    rst = r;
    en  = e;
    din = d;
    @(posedge clk);
    #1;
    if (r) begin
      bits.delete();
      fresh   = 0;
      hits    = 0;
      m_match = 1'b0;
    end else if (e) begin
      bits.push_back(d);
      fresh++;
      hit = 1'b0;
      if (fresh >= N) begin
        hit = 1'b1;
        sz  = bits.size();
        for (int i = 0; i < N; i++)
          if (bits[sz-N+i] != pv[N-1-i]) hit = 1'b0;
      end
      m_match = hit;
      if (hit) begin
        hits++;
`ifndef JSEQ_OVERLAP_EN
        fresh = 0;
`endif
      end
    end else begin
      m_match = 1'b0;
    end
  endtask

  task automatic test_reset();
    tick(1, 0, 0);
    tick(1, 1, 1);
    tests_run++;
    if (match !== 1'b0 || count !== '0 || hist !== '0) begin
      tests_failed++;
      $display("FAIL reset_state: match=%b count=%0d hist=%b, want 0 0 0000", match, count, hist);
    end
    for (int i = 0; i < 4; i++) begin
      tick(0, 1, 0);
      tests_run++;
      if (match !== 1'b0 || count !== '0 || hist !== 4'b0000) begin
        tests_failed++;
        $display("FAIL zeros_no_match[%0d]: match=%b count=%0d hist=%b, want 0 0 0000", i, match, count, hist);
      end
    end
  endtask

  task automatic test_single();
    logic [3:0] s;
    s = 4'b1011;
    tick(1, 0, 0);
    for (int i = 3; i >= 0; i--) begin
      tick(0, 1, s[i]);
      tests_run++;
      if (match !== (i == 0)) begin
        tests_failed++;
        $display("FAIL single_match bit%0d: got %b want %b", 3 - i, match, (i == 0));
      end
    end
    tests_run++;
    if (count !== 4'd1 || hist !== 4'b1011) begin
      tests_failed++;
      $display("FAIL single_state: count=%0d hist=%b, want 1 1011", count, hist);
    end
    tick(0, 0, 1);
    tests_run++;
    if (match !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_pulse_width: got %b want 0", match);
    end
  endtask

  task automatic test_overlap();
    logic [6:0] s;
    int pulses;
    s = 7'b1011011;
    pulses = 0;
    tick(1, 0, 0);
    for (int i = 6; i >= 0; i--) begin
      tick(0, 1, s[i]);
      pulses += int'(match);
      tests_run++;
      if (match !== m_match) begin
        tests_failed++;
        $display("FAIL overlap_match bit%0d: got %b want %b", 6 - i, match, m_match);
      end
    end
    tests_run++;
`ifdef JSEQ_OVERLAP_EN
    if (count !== 4'd2 || pulses != 2) begin
      tests_failed++;
      $display("FAIL overlap_count: count=%0d pulses=%0d, want 2 2", count, pulses);
    end
`else
    if (count !== 4'd1 || pulses != 1) begin
      tests_failed++;
      $display("FAIL overlap_count: count=%0d pulses=%0d, want 1 1", count, pulses);
    end
`endif
  endtask

  task automatic test_enable_gap();
    tick(1, 0, 0);
    tick(0, 1, 1);
    tick(0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, i[0]);
      tests_run++;
      if (hist !== 4'b0010 || match !== 1'b0) begin
        tests_failed++;
        $display("FAIL gap_hold[%0d]: hist=%b match=%b, want 0010 0", i, hist, match);
      end
    end
    tick(0, 1, 1);
    tests_run++;
    if (match !== 1'b0) begin
      tests_failed++;
      $display("FAIL gap_early: got %b want 0", match);
    end
    tick(0, 1, 1);
    tests_run++;
    if (match !== 1'b1 || count !== 4'd1) begin
      tests_failed++;
      $display("FAIL gap_match: match=%b count=%0d, want 1 1", match, count);
    end
  endtask

  task automatic test_reset_mid();
    tick(1, 0, 0);
    tick(0, 1, 1);
    tick(0, 1, 0);
    tick(0, 1, 1);
    tick(1, 1, 1);
    tick(0, 1, 1);
    tests_run++;
    if (match !== 1'b0 || hist !== 4'b0001) begin
      tests_failed++;
      $display("FAIL reset_mid: match=%b hist=%b, want 0 0001", match, hist);
    end
    tick(0, 1, 0);
    tick(0, 1, 1);
    tests_run++;
    if (match !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_fill_early: got %b want 0", match);
    end
    tick(0, 1, 1);
    tests_run++;
    if (match !== 1'b1 || count !== 4'd1) begin
      tests_failed++;
      $display("FAIL reset_mid_fill: match=%b count=%0d, want 1 1", match, count);
    end
  endtask

  task automatic test_saturate();
    logic [3:0] s;
    int pulses;
    s = 4'b1011;
    pulses = 0;
    tick(1, 0, 0);
    for (int k = 0; k < 20; k++) begin
      for (int i = 3; i >= 0; i--) begin
        tick(0, 1, s[i]);
        pulses += int'(match);
      end
      tests_run++;
      if (count !== exp_count()) begin
        tests_failed++;
        $display("FAIL saturate_count[%0d]: got %0d want %0d", k, count, exp_count());
      end
    end
    tests_run++;
    if (pulses != 20 || count !== 4'd15) begin
      tests_failed++;
      $display("FAIL saturate_final: pulses=%0d count=%0d, want 20 15", pulses, count);
    end
  endtask

  task automatic test_random();
    logic r, e, d;
    tick(1, 0, 0);
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 59) == 0);
      e = ($urandom_range(0, 3) != 0);
      d = 1'($urandom);
      tick(r, e, d);
      tests_run++;
      if (match !== m_match || count !== exp_count() || hist !== exp_hist()) begin
        tests_failed++;
        $display("FAIL random[%0d]: match=%b count=%0d hist=%b, want %b %0d %b",
                 i, match, count, hist, m_match, exp_count(), exp_hist());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overlap();
    test_enable_gap();
    test_reset_mid();
    test_saturate();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/jseq_detector.md
# jseq_detector

Serial pattern detector that consumes the 1-bit registered stream produced by the team's D flip-flop stage, one bit per enabled clock. It sits directly downstream of that flip-flop: its `din` is wired to the flip-flop's `q`. It shifts bits into a history register and raises a one-cycle `match` pulse when the last `N` bits equal `PATTERN`. It also keeps a saturating count of matches for board-level display.

## Interface
- `N`, 4: pattern length in bits, minimum 2.
- `PATTERN`, 4'b1011: target sequence; MSB is the oldest bit, LSB is the newest.
- `CW`, 4: width of the match counter.
- `clk`  in  1  rising-edge clock; the only clock in the block.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  sample enable; `din` is consumed only on edges where `en`=1.
- `din`  in  1  serial bit from the upstream flip-flop `q`.
- `match`  out  1  registered one-cycle pulse: last `N` consumed bits equal `PATTERN`.
- `count`  out  CW  number of matches since reset; saturates.
- `hist`  out  N  current history register, for debug and LED display.

## Operation
- Reset values: `hist`=0, fill counter=0, `match`=0, `count`=0.
- `rst` has priority over `en` on every edge.
- On an edge with `en`=1:
  - `hist` <= {hist[N-2:0], din}.
  - Fill counter increments and saturates at `N`.
- Next-history compare: hit = ({hist[N-2:0], din} == PATTERN) and (fill >= N-1).
  - Leading zeros left in `hist` after reset never produce a match. This holds even for PATTERN=0.
- On a hit, `match` <= 1 and `count` <= count+1. The count saturates at 2^CW-1 and does not wrap.
- On any edge with no hit, or with `en`=0, `match` <= 0. `match` is never held high for two cycles by one hit.
- `en`=0: `hist`, fill and `count` hold their values.
- Moore-style FSM on the fill counter:
  - FILL (fill < N-1): no match possible.
  - ARMED (fill >= N-1): compare active.
  - ARMED -> FILL occurs only on reset, or on a hit when overlap is disabled.
- A simultaneous hit and `count` at maximum: `match` still pulses; `count` stays at maximum.

## Timing
- Latency: a bit presented on `din` is sampled at edge k. Any `match` caused by that bit is high from edge k until edge k+1.
- `hist` and `count` update at the same edge as `match`.
- Reset asserted at edge k: all outputs take their reset values after edge k, whatever `en` and `din` are.
- Reset mid-pattern discards any partially matched bits.
- No combinational path from inputs to outputs.

## Configuration
- `JSEQ_OVERLAP_EN` defined: overlapping detection. After a hit, the fill counter stays at `N`, so the suffix of one match can begin the next.
- `JSEQ_OVERLAP_EN` undefined: non-overlapping detection. On a hit, the fill counter resets to 0, and `N` fresh bits are needed for the next match. `hist` still shifts normally.

## Structure
- Shared package `jseq_pkg`: default `N`, `PATTERN` and `CW` constants, plus the FSM state enum (FILL, ARMED).
- One sub-module, `jshiftreg`: an N-bit serial-in, parallel-out register with `clk`, `rst` and `en`. It produces `hist`.
- The top level holds the compare logic, fill counter/FSM, match register and saturating counter.

## Test plan
All scenarios use the defaults N=4, PATTERN=1011, CW=4.
- Reset for 2 cycles, then `en`=1 with `din`=0 for 4 cycles -> `match`=0, `count`=0, `hist`=0000.
- After reset, `din`=1,0,1,1 with `en`=1 -> `match`=1 for exactly the cycle after the 4th edge, then 0; `count`=1, `hist`=1011.
- Stream 1,0,1,1,0,1,1 -> with `JSEQ_OVERLAP_EN`, two pulses at the 4th and 7th bits and `count`=2; without it, one pulse and `count`=1.
- Stream 1,0, then `en`=0 for 3 cycles with `din` toggling, then 1,1 with `en`=1 -> one `match` pulse after the final bit; `hist` unchanged during the `en`=0 gap.
- Stream 1,0,1, assert `rst` for one edge, then `din`=1 -> no match; `hist`=0001, fill=1.
- 20 consecutive non-overlapping 1011 patterns -> 20 `match` pulses; `count` stops at 15 and stays at 15.
